// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Round-robin arbiter for the common data bus. Each producer (index 0 = ALU
//   RS, 1 = MUL RS, 2 = load unit) offers a completed result. At most one is
//   granted per cycle, and the winner is broadcast on a registered CDB in the
//   following cycle. A result whose tag is all-ones is consumed but is not
//   broadcast. It raises err_tag for one cycle instead.
//
//   Ports:
//     clk            rising-edge clock
//     rst            asynchronous active-low reset
//     req_valid      per-requester result valid
//     req_tag        per-requester RS tag, slice i = [TAG_W*i +: TAG_W]
//     req_dest       per-requester destination id, slice i = [5*i +: 5]
//     req_data       per-requester data, slice i = [DATA_W*i +: DATA_W]
//     req_ready      one-hot grant (combinational from valid/ptr/stall/flush)
//     cdb_stall      consumer back-pressure, suppresses grants
//     flush          squash, suppresses grants and the next broadcast
//     cdb_valid      broadcast valid pulse
//     cdb_tag        broadcast tag (all-ones when idle)
//     cdb_dest       broadcast destination id (holds when idle)
//     cdb_data       broadcast data (holds when idle)
//     err_tag        pulse: an accepted request carried the all-ones tag
//
//   Optional feature, enabled by defining the macro CDB_PERF_EN:
//     perf_grant_cnt 16-bit saturating accepted-request count per requester
//     perf_wait_cnt  16-bit saturating count of valid-but-not-ready cycles
module cdb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [TAG_W*N_REQ-1:0]  req_tag,
  input  logic [5*N_REQ-1:0]      req_dest,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    cdb_stall,
  input  logic                    flush,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [4:0]              cdb_dest,
  output logic [DATA_W-1:0]       cdb_data,
`ifdef CDB_PERF_EN
  output logic [16*N_REQ-1:0]     perf_grant_cnt,
  output logic [16*N_REQ-1:0]     perf_wait_cnt,
`endif
  output logic                    err_tag
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [TAG_W-1:0] NO_TAG = '1;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  rr_next;
  logic              grant_any;
  logic [N_REQ-1:0]  grant;
  logic [TAG_W-1:0]  sel_tag;
  logic [4:0]        sel_dest;
  logic [DATA_W-1:0] sel_data;
  logic              sel_illegal;

  // Rotating priority search starting at rr_ptr. The sum is kept one bit wider
  // than the pointer so the wrap to 0 is an explicit subtract of N_REQ.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sum       = '0;
    cand      = '0;
    if (rst && !cdb_stall && !flush) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
        if (sum >= (PTR_W+1)'(N_REQ))
          sum = sum - (PTR_W+1)'(N_REQ);
        cand = sum[PTR_W-1:0];
        if (!grant_any && req_valid[cand]) begin
          grant_any   = 1'b1;
          grant[cand] = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  assign req_ready = grant;

  always_comb begin
    sel_tag     = req_tag[TAG_W*grant_idx +: TAG_W];
    sel_dest    = req_dest[5*grant_idx +: 5];
    sel_data    = req_data[DATA_W*grant_idx +: DATA_W];
    sel_illegal = (sel_tag == NO_TAG);
    rr_next     = (grant_idx == PTR_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= NO_TAG;
      cdb_dest  <= '0;
      cdb_data  <= '0;
      err_tag   <= 1'b0;
    end else begin
      cdb_valid <= grant_any && !sel_illegal;
      err_tag   <= grant_any && sel_illegal;
      if (grant_any)
        rr_ptr <= rr_next;
      if (grant_any && !sel_illegal) begin
        cdb_tag  <= sel_tag;
        cdb_dest <= sel_dest;
        cdb_data <= sel_data;
      end else begin
        cdb_tag  <= NO_TAG;
      end
    end
  end

`ifdef CDB_PERF_EN
  logic [15:0] grant_cnt [N_REQ];
  logic [15:0] wait_cnt  [N_REQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        grant_cnt[i] <= '0;
        wait_cnt[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && grant[i] && grant_cnt[i] != '1)
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
        if (req_valid[i] && !grant[i] && wait_cnt[i] != '1)
          wait_cnt[i] <= wait_cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    perf_grant_cnt = '0;
    perf_wait_cnt  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      perf_grant_cnt[16*i +: 16] = grant_cnt[i];
      perf_wait_cnt[16*i +: 16]  = wait_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [5*N-1:0]  req_tag;
  logic [5*N-1:0]  req_dest;
  logic [32*N-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          cdb_stall, flush;
  logic          cdb_valid;
  logic [4:0]    cdb_tag, cdb_dest;
  logic [31:0]   cdb_data;
  logic          err_tag;

  cdb_arbiter #(.N_REQ(N), .TAG_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_tag(req_tag),
    .req_dest(req_dest), .req_data(req_data), .req_ready(req_ready),
    .cdb_stall(cdb_stall), .flush(flush), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_dest(cdb_dest), .cdb_data(cdb_data),
    .err_tag(err_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        e;
    logic [4:0]  tag;
    logic [4:0]  dest;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Requester-side state: a pending result stays offered until granted.
  logic        v   [N];
  logic [4:0]  t   [N];
  logic [4:0]  d   [N];
  logic [31:0] dat [N];

  // Reference model state.
  int          m_rr;
  logic [4:0]  m_dest;
  logic [31:0] m_data;
  int          grant_log[$];

  function automatic int model_pick();
    int order[$];
    for (int k = 0; k < N; k++) order.push_back((m_rr + k) % N);
    foreach (order[j]) if (v[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One cycle: drive at negedge, check req_ready, queue the expected CDB.
  task automatic step(input logic stall, input logic fl);
    int g;
    exp_t e;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    cdb_stall = stall;
    flush     = fl;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = v[i];
      req_tag[5*i +: 5]     = t[i];
      req_dest[5*i +: 5]    = d[i];
      req_data[32*i +: 32]  = dat[i];
    end
    #1;
    g = (stall || fl) ? -1 : model_pick();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    e.v = 1'b0; e.e = 1'b0; e.tag = 5'h1F;
    if (g >= 0) begin
      grant_log.push_back(g);
      m_rr = (g + 1) % N;
      if (t[g] == 5'h1F) e.e = 1'b1;
      else begin
        e.v = 1'b1; e.tag = t[g]; m_dest = d[g]; m_data = dat[g];
      end
      v[g] = 1'b0;
    end
    e.dest = m_dest;
    e.data = m_data;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expected entry per edge after a cycle was issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (cdb_valid !== e.v || err_tag !== e.e || cdb_tag !== e.tag ||
            cdb_dest !== e.dest || cdb_data !== e.data) begin
          failures++;
          $display("FAIL cdb: got v=%b e=%b tag=%h dest=%h data=%h expected v=%b e=%b tag=%h dest=%h data=%h",
                   cdb_valid, err_tag, cdb_tag, cdb_dest, cdb_data,
                   e.v, e.e, e.tag, e.dest, e.data);
        end
      end
    end
  end

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; t[i] = '0; d[i] = '0; dat[i] = '0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    req_valid = '1;
    cdb_stall = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(cdb_valid), 32'd0);
    chk("rst_tag", 32'(cdb_tag), 32'h1F);
    chk("rst_dest", 32'(cdb_dest), 32'd0);
    chk("rst_data", cdb_data, 32'd0);
    chk("rst_err", 32'(err_tag), 32'd0);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    clear_reqs();
    m_rr = 0; m_dest = '0; m_data = '0;
    grant_log.delete();
  endtask

  task automatic expect_order(input string name, input int exp_o[$]);
    chk({name, "_len"}, 32'(grant_log.size()), 32'(exp_o.size()));
    foreach (exp_o[j])
      if (j < grant_log.size()) chk(name, 32'(grant_log[j]), 32'(exp_o[j]));
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_tag = '0; req_dest = '0; req_data = '0;
    cdb_stall = 1'b0; flush = 1'b0;
    clear_reqs();
    m_rr = 0; m_dest = '0; m_data = '0;

    // Reset then idle.
    do_reset();
    repeat (10) step(1'b0, 1'b0);

    // Single MUL result.
    v[1] = 1'b1; t[1] = 5'd18; d[1] = 5'd7; dat[1] = 32'd42;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Round-robin with all three continuously valid.
    do_reset();
    t[0] = 5'd1; t[1] = 5'd17; t[2] = 5'd9;
    d[0] = 5'd3; d[1] = 5'd4; d[2] = 5'd5;
    dat[0] = 32'hA0; dat[1] = 32'hA1; dat[2] = 32'hA2;
    repeat (6) begin
      for (int i = 0; i < N; i++) v[i] = 1'b1;
      step(1'b0, 1'b0);
    end
    expect_order("rr_order", '{0, 1, 2, 0, 1, 2});
    clear_reqs();
    step(1'b0, 1'b0);

    // Stall: requester 1 waits out 4 stalled cycles.
    grant_log.delete();
    v[1] = 1'b1; t[1] = 5'd6; d[1] = 5'd12; dat[1] = 32'hDEAD_BEEF;
    repeat (4) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    expect_order("stall_order", '{1});

    // Flush collides with requesters 0 and 2; pointer is at 2 after the stall test.
    grant_log.delete();
    v[0] = 1'b1; t[0] = 5'd2; d[0] = 5'd1; dat[0] = 32'h11;
    v[2] = 1'b1; t[2] = 5'd3; d[2] = 5'd2; dat[2] = 32'h22;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    expect_order("flush_order", '{2, 0});

    // Illegal tag from requester 0, then pointer must favour requester 1.
    do_reset();
    v[0] = 1'b1; t[0] = 5'h1F; d[0] = 5'd9; dat[0] = 32'h99;
    step(1'b0, 1'b0);
    v[0] = 1'b1; t[0] = 5'd4;
    v[1] = 1'b1; t[1] = 5'd5; d[1] = 5'd10; dat[1] = 32'h55;
    step(1'b0, 1'b0);
    expect_order("illegal_order", '{0, 1});
    clear_reqs();
    step(1'b0, 1'b0);

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && ($urandom_range(0, 99) < 55)) begin
          v[i]   = 1'b1;
          t[i]   = ($urandom_range(0, 9) == 0) ? 5'h1F : 5'($urandom_range(0, 30));
          d[i]   = 5'($urandom);
          dat[i] = $urandom;
        end
      end
      step($urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
    end

    // Drain the random phase before the asynchronous reset check.
    for (int c = 0; c < 200 && (v[0] || v[1] || v[2]); c++) step(1'b0, 1'b0);
    chk("drain_pending", 32'({v[0], v[1], v[2]}), 32'd0);

    // Reset mid-broadcast clears cdb_valid without waiting for an edge.
    v[2] = 1'b1; t[2] = 5'd8; d[2] = 5'd8; dat[2] = 32'h88;
    step(1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_valid", 32'(cdb_valid), 32'd0);
    chk("async_tag", 32'(cdb_tag), 32'h1F);
    @(negedge clk);
    rst = 1'b1;
    clear_reqs();
    m_rr = 0; m_dest = '0; m_data = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between result producers: ALU reservation station, multiply reservation station, load unit.
- Each producer offers a completed result (RS tag, destination register id, 32-bit data) via valid/ready.
- Arbiter grants at most one per cycle, round-robin, and broadcasts the winner on a registered CDB. The register file/FLR and all reservation stations snoop that bus to wake dependent entries.

Parameters:
- N_REQ, 3, number of requesters (index 0 = ALU RS, 1 = MUL RS, 2 = load unit); legal range 2..8
- TAG_W, 5, RS tag width; all-ones tag (5'h1F) means "no tag / data valid"
- DATA_W, 32, result data width

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- req_valid  input  N_REQ  requester i has a result
- req_tag  input  TAG_W*N_REQ  producing RS tag, slice i = [TAG_W*i +: TAG_W]
- req_dest  input  5*N_REQ  destination register id, slice i = [5*i +: 5]
- req_data  input  DATA_W*N_REQ  result data, slice i = [DATA_W*i +: DATA_W]
- req_ready  output  N_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- cdb_stall  input  1  consumer back-pressure; no grant while high
- flush  input  1  squash; no grant, kills pending broadcast
- cdb_valid  output  1  broadcast valid, one-cycle pulse per accepted result
- cdb_tag  output  TAG_W  broadcast RS tag
- cdb_dest  output  5  broadcast destination id
- cdb_data  output  DATA_W  broadcast data
- err_tag  output  1  one-cycle pulse: accepted request carried tag 5'h1F

Behaviour:
- Reset (rst=0, async): cdb_valid=0, cdb_tag=5'h1F, cdb_dest=0, cdb_data=0, err_tag=0, rr_ptr=0. req_ready=0 while in reset.
- req_ready is combinational from req_valid, rr_ptr, cdb_stall and flush. No combinational path from req_tag/req_dest/req_data to req_ready.
- Grant: if cdb_stall=0 and flush=0, search i = rr_ptr, rr_ptr+1, ... mod N_REQ. The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits stay 0.
- rr_ptr update on a grant to i: (i+1) mod N_REQ. With no grant, rr_ptr holds.
- Latency: accepted at edge N, so cdb_valid=1 with captured tag/dest/data during cycle N+1 (exactly one cycle).
- No grant at edge N means cdb_valid=0 in cycle N+1. cdb_tag returns to 5'h1F and cdb_dest/cdb_data hold their last values.
- Back-to-back grants give continuous cdb_valid with new payload each cycle.
- Requester protocol: payload must stay stable while valid=1 and ready=0. A requester must not drop valid before acceptance. The arbiter holds no copy of unaccepted requests.
- Illegal tag: an accepted request with tag 5'h1F is consumed (ready=1) but not broadcast. cdb_valid=0 next cycle, err_tag=1 next cycle, rr_ptr still advances.
- cdb_stall=1: all req_ready=0, rr_ptr holds, next-cycle cdb_valid=0. Stall does not extend an already-registered broadcast.
- flush=1: all req_ready=0, next-cycle cdb_valid=0 and err_tag=0. rr_ptr holds. flush has priority over cdb_stall (same outcome).
- Reset asserted mid-broadcast clears cdb_valid immediately (asynchronous).
- Single requester continuously valid: granted every cycle, full bus throughput.
- All N_REQ valid continuously: each granted exactly once per N_REQ cycles.

Optional Feature:
- Macro: CDB_PERF_EN.
- Defined:
  - Adds output perf_grant_cnt (16*N_REQ): per-requester 16-bit saturating count of accepted requests.
  - Adds output perf_wait_cnt (16*N_REQ): per-requester 16-bit saturating count of cycles with req_valid=1 and req_ready=0.
  - Both counters clear on reset, hold at 16'hFFFF, and are unaffected by flush.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset then idle: rst low 3 cycles, release, no requests -> cdb_valid=0, cdb_tag=5'h1F, req_ready=0 for 10 cycles.
- Single MUL result: req_valid=3'b010, tag=5'd18, dest=5'd7, data=32'd42 -> req_ready=3'b010 that cycle; next cycle cdb_valid=1, cdb_tag=18, cdb_dest=7, cdb_data=42; following cycle cdb_valid=0.
- Round-robin: all three valid continuously from rr_ptr=0 (tags 1, 17, 9) -> grant order 0,1,2,0,1,2; cdb_tag sequence 1,17,9,1,17,9 with cdb_valid high every cycle.
- Stall: requester 1 valid, cdb_stall=1 for 4 cycles then 0 -> req_ready=0 for 4 cycles; granted in the cycle stall drops; cdb_valid=1 one cycle later; rr_ptr unchanged during stall.
- Flush collision: flush=1 in the same cycle requesters 0 and 2 are valid -> no ready, cdb_valid=0 next cycle; flush=0 next cycle -> requester rr_ptr-first granted.
- Illegal tag: requester 0 valid with tag 5'h1F -> ready=1, next cycle cdb_valid=0 and err_tag=1; rr_ptr advances to 1.
